// File: rtl/frame_stat_pkg.sv
// frame_stat_pkg: shared FSM state type and pixel range constants for the
// frame statistics blocks.
package frame_stat_pkg;

    // Pixel width the range constants are built for.
    localparam int PIX_DW = 8;

    localparam logic [PIX_DW-1:0] DATA_MIN = {PIX_DW{1'b0}};
    localparam logic [PIX_DW-1:0] DATA_MAX = {PIX_DW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_PUBLISH = 2'd2
    } state_t;

endpackage

// File: rtl/line_pos_counter.sv
// line_pos_counter: tracks the column/row of the current pixel from href/valid
// and decides which valid pixels are sampled (every SAMPLE_DIV-th pixel of a line).
module line_pos_counter #(
    parameter int XW         = 11,
    parameter int YW         = 11,
    parameter int SAMPLE_DIV = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          href,
    input  logic          valid,
    input  logic          y_clr,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          sample_en
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

    logic             href_r;
    logic [XW-1:0]    x_r;
    logic [YW-1:0]    y_r;
    logic [DIV_W-1:0] div_cnt_r;

    logic             href_rise_s;
    logic             href_fall_s;
    logic             pix_s;
    logic [DIV_W-1:0] div_cur_s;
    logic [DIV_W-1:0] div_nxt_s;

    assign href_rise_s = href & ~href_r;
    assign href_fall_s = ~href & href_r;
    assign pix_s       = href & valid;

    // Decimation phase: a new line restarts the phase on its very first pixel.
    always_comb begin
        div_cur_s = div_cnt_r;
        div_nxt_s = div_cnt_r;
        if (href_rise_s) begin
            div_cur_s = {DIV_W{1'b0}};
        end else begin
            div_cur_s = div_cnt_r;
        end
        if (pix_s) begin
            if (div_cur_s == DIV_LAST) begin
                div_nxt_s = {DIV_W{1'b0}};
            end else begin
                div_nxt_s = div_cur_s + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end else begin
            div_nxt_s = div_cur_s;
        end
    end

    assign sample_en = pix_s & (div_cur_s == {DIV_W{1'b0}});
    assign x         = x_r;
    assign y         = y_r;

    // href edge history, saturating column/row counters and decimation phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_r    <= 1'b0;
            x_r       <= {XW{1'b0}};
            y_r       <= {YW{1'b0}};
            div_cnt_r <= {DIV_W{1'b0}};
        end else begin
            href_r    <= href;
            div_cnt_r <= div_nxt_s;
            if (href_fall_s) begin
                x_r <= {XW{1'b0}};
            end else if (pix_s && (x_r != {XW{1'b1}})) begin
                x_r <= x_r + {{(XW-1){1'b0}}, 1'b1};
            end
            if (y_clr) begin
                y_r <= {YW{1'b0}};
            end else if (href_fall_s && (y_r != {YW{1'b1}})) begin
                y_r <= y_r + {{(YW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/frame_peak_tracker.sv
// frame_peak_tracker: per-frame max/min tracker with position of the maximum,
// published once per frame at the vsync rising edge.
// Build macro PEAK_DECAY_EN: the published maximum falls by at most DECAY_STEP
// per frame instead of following a smaller frame maximum.
module frame_peak_tracker
    import frame_stat_pkg::*;
#(
    parameter int DW         = PIX_DW,
    parameter int XW         = 11,
    parameter int YW         = 11,
    parameter int SAMPLE_DIV = 1,
    parameter int DECAY_STEP = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] indata,
    input  logic          cmos_frame_vsync,
    input  logic          cmos_frame_href,
    input  logic          cmos_frame_valid,
    output logic [DW-1:0] max_data,
    output logic [DW-1:0] min_data,
    output logic [XW-1:0] max_x,
    output logic [YW-1:0] max_y,
    output logic          result_valid,
    output logic          frame_empty
);

    // Marker block that only elaborates for a nonsensical negative decay step.
    if (DECAY_STEP < 0) begin : g_decay_step_negative
    end

    state_t        state_r;
    logic          vsync_r;
    logic          rise_s;

    logic [DW-1:0] acc_max_r;
    logic [DW-1:0] acc_min_r;
    logic [XW-1:0] acc_x_r;
    logic [YW-1:0] acc_y_r;
    logic          seen_r;

    logic [DW-1:0] max_data_r;
    logic [DW-1:0] min_data_r;
    logic [XW-1:0] max_x_r;
    logic [YW-1:0] max_y_r;
    logic          result_valid_r;
    logic          frame_empty_r;

    logic [XW-1:0] x_s;
    logic [YW-1:0] y_s;
    logic          sample_en_s;
    logic          y_clr_s;
    logic          acc_en_s;

    assign rise_s   = cmos_frame_vsync & ~vsync_r;
    // Row count only runs inside a tracked frame.
    assign y_clr_s  = (state_r != S_ACTIVE);
    // The pixel coinciding with the frame boundary belongs to neither frame.
    assign acc_en_s = (state_r == S_ACTIVE) & ~rise_s & sample_en_s;

`ifdef PEAK_DECAY_EN
    logic [DW-1:0] held_s;
    assign held_s = (max_data_r >= DW'(DECAY_STEP)) ? (max_data_r - DW'(DECAY_STEP)) : DATA_MIN;
`endif

    line_pos_counter #(
        .XW         (XW),
        .YW         (YW),
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .href      (cmos_frame_href),
        .valid     (cmos_frame_valid),
        .y_clr     (y_clr_s),
        .x         (x_s),
        .y         (y_s),
        .sample_en (sample_en_s)
    );

    // vsync history for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r <= 1'b0;
        end else begin
            vsync_r <= cmos_frame_vsync;
        end
    end

    // Running extremes of the current frame; restart outside active tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_max_r <= DATA_MIN;
            acc_min_r <= DATA_MAX;
            acc_x_r   <= {XW{1'b0}};
            acc_y_r   <= {YW{1'b0}};
            seen_r    <= 1'b0;
        end else if (state_r != S_ACTIVE) begin
            acc_max_r <= DATA_MIN;
            acc_min_r <= DATA_MAX;
            acc_x_r   <= {XW{1'b0}};
            acc_y_r   <= {YW{1'b0}};
            seen_r    <= 1'b0;
        end else if (acc_en_s) begin
            seen_r <= 1'b1;
            if (indata > acc_max_r) begin
                acc_max_r <= indata;
                acc_x_r   <= x_s;
                acc_y_r   <= y_s;
            end
            if (indata < acc_min_r) begin
                acc_min_r <= indata;
            end
        end
    end

    // Frame FSM and the registered result set it publishes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= S_IDLE;
            max_data_r     <= DATA_MIN;
            min_data_r     <= DATA_MIN;
            max_x_r        <= {XW{1'b0}};
            max_y_r        <= {YW{1'b0}};
            result_valid_r <= 1'b0;
            frame_empty_r  <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    state_r <= rise_s ? S_ACTIVE : S_IDLE;
                end
                S_ACTIVE: begin
                    state_r <= rise_s ? S_PUBLISH : S_ACTIVE;
                end
                S_PUBLISH: begin
                    state_r        <= S_ACTIVE;
                    result_valid_r <= 1'b1;
                    frame_empty_r  <= ~seen_r;
                    min_data_r     <= seen_r ? acc_min_r : DATA_MIN;
`ifdef PEAK_DECAY_EN
                    if (seen_r && (acc_max_r >= held_s)) begin
                        max_data_r <= acc_max_r;
                        max_x_r    <= acc_x_r;
                        max_y_r    <= acc_y_r;
                    end else begin
                        max_data_r <= held_s;
                    end
`else
                    max_data_r <= seen_r ? acc_max_r : DATA_MIN;
                    max_x_r    <= seen_r ? acc_x_r : {XW{1'b0}};
                    max_y_r    <= seen_r ? acc_y_r : {YW{1'b0}};
`endif
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign max_data     = max_data_r;
    assign min_data     = min_data_r;
    assign max_x        = max_x_r;
    assign max_y        = max_y_r;
    assign result_valid = result_valid_r;
    assign frame_empty  = frame_empty_r;

endmodule

// File: tb/tb_frame_peak_tracker.sv
// tb_frame_peak_tracker: directed frames into two trackers (every pixel and
// every second pixel sampled), checked each cycle against a frame-level model.
module tb_frame_peak_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] indata = 8'd0;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic       valid = 1'b0;

    logic [7:0]  max1, min1, max2, min2;
    logic [10:0] mx1, my1, mx2, my2;
    logic        rv1, fe1, rv2, fe2;

    always #5 clk = ~clk;

    frame_peak_tracker #(.DW(8), .XW(11), .YW(11), .SAMPLE_DIV(1), .DECAY_STEP(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .indata(indata), .cmos_frame_vsync(vsync),
        .cmos_frame_href(href), .cmos_frame_valid(valid),
        .max_data(max1), .min_data(min1), .max_x(mx1), .max_y(my1),
        .result_valid(rv1), .frame_empty(fe1)
    );

    frame_peak_tracker #(.DW(8), .XW(11), .YW(11), .SAMPLE_DIV(2), .DECAY_STEP(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .indata(indata), .cmos_frame_vsync(vsync),
        .cmos_frame_href(href), .cmos_frame_valid(valid),
        .max_data(max2), .min_data(min2), .max_x(mx2), .max_y(my2),
        .result_valid(rv2), .frame_empty(fe2)
    );

    typedef struct { int v; int c; int r; } pix_t;
    typedef struct { int mx; int mn; int x; int y; bit empty; } res_t;

    pix_t frame_q[$];
    res_t exp_r[2];
    res_t pend_r[2];
    int   lbuf[16];
    int   row = 0;
    bit   model_active = 1'b0;
    int   cyc = 0;
    int   pub_cyc = -1;
    bit   exp_rv = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Result a tracker must publish for the pixels of the finished frame.
    function automatic res_t model_publish(input res_t prev, input int div);
        res_t r;
        int   mxv, mnv, px, py, held;
        bit   seen;
        mxv = 0; mnv = 255; px = 0; py = 0; seen = 1'b0;
        foreach (frame_q[i]) begin
            if ((frame_q[i].c % div) == 0) begin
                seen = 1'b1;
                if (frame_q[i].v > mxv) begin
                    mxv = frame_q[i].v; px = frame_q[i].c; py = frame_q[i].r;
                end
                if (frame_q[i].v < mnv) mnv = frame_q[i].v;
            end
        end
        r.empty = !seen;
        r.mn    = seen ? mnv : 0;
`ifdef PEAK_DECAY_EN
        held = (prev.mx >= 4) ? prev.mx - 4 : 0;
        if (seen && mxv >= held) begin
            r.mx = mxv; r.x = px; r.y = py;
        end else begin
            r.mx = held; r.x = prev.x; r.y = prev.y;
        end
`else
        held = prev.mx;
        r.mx = seen ? mxv : 0;
        r.x  = seen ? px : 0;
        r.y  = seen ? py : 0;
`endif
        return r;
    endfunction

    // Per-cycle comparison of both trackers against the model.
    always @(posedge clk) begin
        #1;
        cyc++;
        exp_rv = (cyc == pub_cyc);
        if (exp_rv) begin
            exp_r[0] = pend_r[0];
            exp_r[1] = pend_r[1];
        end
        chk("d1_rv", rv1, exp_rv);   chk("d2_rv", rv2, exp_rv);
        chk("d1_max", max1, exp_r[0].mx); chk("d2_max", max2, exp_r[1].mx);
        chk("d1_min", min1, exp_r[0].mn); chk("d2_min", min2, exp_r[1].mn);
        chk("d1_x", mx1, exp_r[0].x); chk("d2_x", mx2, exp_r[1].x);
        chk("d1_y", my1, exp_r[0].y); chk("d2_y", my2, exp_r[1].y);
        chk("d1_empty", fe1, exp_r[0].empty); chk("d2_empty", fe2, exp_r[1].empty);
    end

    task automatic do_reset();
        rst_n = 1'b0; href = 1'b0; valid = 1'b0; vsync = 1'b0; indata = 8'd0;
        model_active = 1'b0; frame_q.delete(); pub_cyc = -1;
        for (int k = 0; k < 2; k++) exp_r[k] = '{0, 0, 0, 0, 1'b0};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic boundary();
        vsync = 1'b1;
        if (model_active) begin
            pend_r[0] = model_publish(exp_r[0], 1);
            pend_r[1] = model_publish(exp_r[1], 2);
            pub_cyc   = cyc + 2;
        end
        model_active = 1'b1; frame_q.delete(); row = 0;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // lbuf entries < 0 are cycles with valid low inside the line.
    task automatic drive_line(input int n);
        int c;
        c = 0;
        for (int i = 0; i < n; i++) begin
            href = 1'b1;
            if (lbuf[i] < 0) begin
                valid = 1'b0; indata = 8'd0;
            end else begin
                valid = 1'b1; indata = lbuf[i][7:0];
                if (model_active) frame_q.push_back('{lbuf[i], c, row});
                c++;
            end
            @(negedge clk);
        end
        href = 1'b0; valid = 1'b0; indata = 8'd0; row++;
        repeat (2) @(negedge clk);
    endtask

    task automatic frame_peak(input int base, input int peak, input int pc, input int pr, input int nrows);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < 4; c++) lbuf[c] = (r == pr && c == pc) ? peak : base;
            drive_line(4);
        end
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        chk("reset_max", max1, 8'd0);
        chk("reset_rv", rv1, 1'b0);

        // Frame with a single bright pixel at (2,1).
        boundary();
        frame_peak(10, 200, 2, 1, 4);
        boundary();
        chk("t1_max", max1, 8'd200); chk("t1_min", min1, 8'd10);
        chk("t1_x", mx1, 11'd2);     chk("t1_y", my1, 11'd1);

        // Frame with no active line.
        boundary();
`ifdef PEAK_DECAY_EN
        chk("t4_max", max1, 8'd196); chk("t4_x", mx1, 11'd2); chk("t4_y", my1, 11'd1);
`else
        chk("t4_max", max1, 8'd0);   chk("t4_x", mx1, 11'd0); chk("t4_y", my1, 11'd0);
`endif
        chk("t4_min", min1, 8'd0);   chk("t4_empty", fe1, 1'b1);

        // Two equal peaks: the first one's position must be kept.
        lbuf[0] = 255; lbuf[1] = 1; lbuf[2] = 2; lbuf[3] = 3; drive_line(4);
        lbuf[0] = 4;   lbuf[1] = 4; lbuf[2] = 4; lbuf[3] = 4; drive_line(4);
        lbuf[0] = 9;   lbuf[1] = 9; lbuf[2] = 9; lbuf[3] = 255; drive_line(4);
        boundary();
        chk("t2_max", max1, 8'd255); chk("t2_x", mx1, 11'd0); chk("t2_y", my1, 11'd0);
        chk("t2_min", min1, 8'd1);   chk("t2_empty", fe1, 1'b0);

        // Decimation: 250 falls on an unsampled pixel for the divide-by-2 tracker.
        lbuf[0] = 5; lbuf[1] = 250; lbuf[2] = -1; lbuf[3] = 6; lbuf[4] = 7; drive_line(5);
        boundary();
`ifdef PEAK_DECAY_EN
        chk("t3_d2_max", max2, 8'd251); chk("t3_d1_max", max1, 8'd251);
`else
        chk("t3_d2_max", max2, 8'd6);   chk("t3_d1_max", max1, 8'd250);
        chk("t3_d1_x", mx1, 11'd1);
`endif
        chk("t3_d2_min", min2, 8'd5);

        // Reset in the middle of a line, then a partial frame before tracking resumes.
        href = 1'b1; valid = 1'b1; indata = 8'd77;
        repeat (2) @(negedge clk);
        do_reset();
        frame_peak(30, 120, 1, 0, 1);
        boundary();
        chk("t5_rv", rv1, 1'b0); chk("t5_max", max1, 8'd0);

        // Peak sequence 100, 98, 100, 50.
        frame_peak(20, 100, 1, 0, 2); boundary();
        chk("t6a_max", max1, 8'd100);
        frame_peak(20, 98, 3, 1, 2);  boundary();
        chk("t6b_max", max1, 8'd98); chk("t6b_x", mx1, 11'd3); chk("t6b_y", my1, 11'd1);
        frame_peak(20, 100, 2, 0, 2); boundary();
        frame_peak(20, 50, 0, 2, 3);  boundary();
`ifdef PEAK_DECAY_EN
        chk("t6d_max", max1, 8'd96); chk("t6d_x", mx1, 11'd2); chk("t6d_y", my1, 11'd0);
`else
        chk("t6d_max", max1, 8'd50); chk("t6d_x", mx1, 11'd0); chk("t6d_y", my1, 11'd2);
`endif
        chk("t6d_min", min1, 8'd20);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
